// File: rtl/arm_pkg.sv
// Shared ARM condition-code constants and flag layout used by the status
// register unit and the ID-stage condition checker.
package arm_pkg;

  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned FLAGS_W   = 4;
  localparam int unsigned WIN_CNT_W = 3;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic cond_uses_flags(input logic [3:0] cond);
    return (cond != COND_AL) && (cond != COND_NV);
  endfunction

endpackage

// File: rtl/flag_pending_pipe.sv
// Tracks in-flight flag setters between ID issue and the EXE flag write, and
// the post-flush window during which an untracked flag write is tolerated.
module flag_pending_pipe #(
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_i,
  input  logic                  freeze_i,
  input  logic                  flush_i,
  output logic [PIPE_DEPTH-1:0] pending_o,
  output logic                  mask_o
);
  import arm_pkg::*;

  logic [PIPE_DEPTH-1:0] p_q, p_d;
  logic [WIN_CNT_W-1:0]  win_q, win_d;

  // The window counts real cycles, freeze included; a flush is only honoured
  // when the pipeline is not frozen.
  always_comb begin
    p_d   = p_q;
    win_d = win_q;
    if (win_q != '0) begin
      win_d = win_q - WIN_CNT_W'(1);
    end
    if (!freeze_i) begin
      if (flush_i) begin
        p_d   = '0;
        win_d = WIN_CNT_W'(PIPE_DEPTH);
      end else begin
        p_d = PIPE_DEPTH'({p_q, issue_i});
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_q   <= '0;
      win_q <= '0;
    end else begin
      p_q   <= p_d;
      win_q <= win_d;
    end
  end

  assign pending_o = p_q;
  assign mask_o    = (win_q != '0);

endmodule

// File: rtl/status_register_unit.sv
// Architectural NZCV register with zero-latency EXE bypass, RAW stall for
// conditional instructions in ID, and sticky detection of untracked writes.
module status_register_unit #(
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic       id_s,
  input  logic [3:0] id_cond,
  input  logic       exe_wr,
  input  logic [3:0] exe_flags,
  input  logic       freeze,
  input  logic       flush,
  output logic       flag_n,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_v,
  output logic       stall,
  output logic       err
);
  import arm_pkg::*;

  // Only the younger pending stages stall; the oldest one is covered by the bypass.
  localparam logic [PIPE_DEPTH-1:0] STALL_MASK =
    PIPE_DEPTH'((1 << (PIPE_DEPTH - 1)) - 1);

  flags_t                f_q, f_d;
  logic                  err_q, err_d;
  logic [PIPE_DEPTH-1:0] pending;
  logic                  mask;
  logic                  issue;
  logic [FLAGS_W-1:0]    flags_c;

  flag_pending_pipe #(
    .PIPE_DEPTH(PIPE_DEPTH)
  ) u_pending (
    .clk_i    (clk),
    .rst_i    (rst),
    .issue_i  (issue),
    .freeze_i (freeze),
    .flush_i  (flush),
    .pending_o(pending),
    .mask_o   (mask)
  );

  assign stall = id_valid & cond_uses_flags(id_cond) & (|(pending & STALL_MASK));
  assign issue = id_valid & id_s & ~stall & ~freeze & ~flush;

  assign flags_c = exe_wr ? exe_flags : FLAGS_W'(f_q);
  assign flag_n  = flags_c[FLAG_N];
  assign flag_z  = flags_c[FLAG_Z];
  assign flag_c  = flags_c[FLAG_C];
  assign flag_v  = flags_c[FLAG_V];

  // F commits on every exe_wr, even under freeze or flush; err is held while frozen.
  always_comb begin
    f_d   = f_q;
    err_d = err_q;
    if (exe_wr) begin
      f_d = flags_t'(exe_flags);
    end
    if (!freeze) begin
      err_d = err_q | (exe_wr & ~pending[PIPE_DEPTH-1] & ~mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q   <= '0;
      err_q <= 1'b0;
    end else begin
      f_q   <= f_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_status_register_unit.sv
// Self-checking bench for status_register_unit (PIPE_DEPTH=2): directed test
// plan scenarios followed by random traffic against an age-list reference model.
module tb_status_register_unit;

  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic       id_s = 1'b0;
  logic [3:0] id_cond = 4'b1110;
  logic       exe_wr = 1'b0;
  logic [3:0] exe_flags = 4'b0000;
  logic       freeze = 1'b0;
  logic       flush = 1'b0;
  logic       flag_n, flag_z, flag_c, flag_v, stall, err;

  always #5 clk = ~clk;

  status_register_unit #(.PIPE_DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .id_valid (id_valid),
    .id_s     (id_s),
    .id_cond  (id_cond),
    .exe_wr   (exe_wr),
    .exe_flags(exe_flags),
    .freeze   (freeze),
    .flush    (flush),
    .flag_n   (flag_n),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .flag_v   (flag_v),
    .stall    (stall),
    .err      (err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: F, sticky err, and the age (cycles since issue) of each
  // flag setter still in flight.
  logic [3:0] m_f = 4'b0000;
  logic       m_err = 1'b0;
  bit         m_known = 1'b0;
  int         ages[$];
  int         cyc = 0;
  int         last_flush = 0;
  bit         have_flush = 1'b0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {3'b000, obs}, {3'b000, exp});
  endtask

  function automatic bit m_uses(input logic [3:0] c);
    return (c != 4'b1110) && (c != 4'b1111);
  endfunction

  function automatic bit m_stall();
    if (!id_valid || !m_uses(id_cond)) return 1'b0;
    foreach (ages[i]) if (ages[i] < D) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_top();
    foreach (ages[i]) if (ages[i] == D) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_masked();
    return have_flush && (cyc - last_flush >= 1) && (cyc - last_flush <= D);
  endfunction

  task automatic drive(input logic v, input logic s, input logic [3:0] c,
                       input logic wr, input logic [3:0] fl,
                       input logic frz, input logic flsh, input logic r);
    id_valid  = v;
    id_s      = s;
    id_cond   = c;
    exe_wr    = wr;
    exe_flags = fl;
    freeze    = frz;
    flush     = flsh;
    rst       = r;
    #1;
  endtask

  // Check all outputs against the model, then advance one clock edge.
  task automatic tick();
    bit st, top, iss, msk;
    int nxt[$];
    chk("flags", {flag_n, flag_z, flag_c, flag_v}, exe_wr ? exe_flags : m_f);
    st = m_stall();
    chk1("stall", stall, st);
    if (m_known) chk1("err", err, m_err);
    top = m_top();
    msk = m_masked();
    iss = id_valid && id_s && !st && !freeze && !flush;
    @(posedge clk);
    if (rst) begin
      m_f        = 4'b0000;
      m_err      = 1'b0;
      m_known    = 1'b1;
      ages       = {};
      have_flush = 1'b0;
    end else begin
      if (exe_wr) m_f = exe_flags;
      if (!freeze) begin
        if (exe_wr && !top && !msk) m_err = 1'b1;
        if (flush) begin
          ages       = {};
          have_flush = 1'b1;
          last_flush = cyc;
        end else begin
          foreach (ages[i]) if (ages[i] + 1 <= D) nxt.push_back(ages[i] + 1);
          if (iss) nxt.push_back(1);
          ages = nxt;
        end
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r, frz, flsh, v, s, wr;
    logic [3:0] c, fl;

    // Reset: outputs follow the bypass while rst is held.
    drive(0, 0, 4'b1110, 1, 4'b1111, 0, 0, 1);
    chk("rst_bypass", {flag_n, flag_z, flag_c, flag_v}, 4'b1111);
    tick();
    tick();
    drive(0, 0, 4'b1110, 0, 4'b0000, 0, 0, 0);
    chk("post_rst_flags", {flag_n, flag_z, flag_c, flag_v}, 4'b0000);
    chk1("post_rst_stall", stall, 1'b0);
    chk1("post_rst_err", err, 1'b0);
    tick();

    // RAW stall on EQ behind a setter, resolved by the bypass.
    drive(1, 1, 4'b1110, 0, 4'b0000, 0, 0, 0);
    tick();
    drive(1, 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    chk1("raw_stall_t1", stall, 1'b1);
    tick();
    drive(1, 0, 4'b0000, 1, 4'b0100, 0, 0, 0);
    chk1("raw_stall_t2", stall, 1'b0);
    chk1("raw_bypass_z", flag_z, 1'b1);
    tick();
    drive(0, 0, 4'b1110, 0, 4'b0000, 0, 0, 0);
    chk("raw_f_t3", {flag_n, flag_z, flag_c, flag_v}, 4'b0100);
    tick();

    // AL and NV never stall; back-to-back setters write in turn.
    drive(1, 1, 4'b1110, 0, 4'b0000, 0, 0, 0);
    tick();
    drive(1, 1, 4'b1110, 0, 4'b0000, 0, 0, 0);
    chk1("al_no_stall", stall, 1'b0);
    tick();
    drive(1, 0, 4'b1111, 1, 4'b1000, 0, 0, 0);
    chk1("nv_no_stall", stall, 1'b0);
    tick();
    drive(0, 0, 4'b1110, 1, 4'b0001, 0, 0, 0);
    tick();
    drive(0, 0, 4'b1110, 0, 4'b0000, 0, 0, 0);
    chk("b2b_last_write", {flag_n, flag_z, flag_c, flag_v}, 4'b0001);
    chk1("b2b_err", err, 1'b0);
    tick();

    // Flush kills the setter; stray write inside the window is tolerated.
    drive(1, 1, 4'b1110, 0, 4'b0000, 0, 0, 0);
    tick();
    drive(0, 0, 4'b1110, 0, 4'b0000, 0, 1, 0);
    tick();
    drive(1, 0, 4'b0000, 1, 4'b0010, 0, 0, 0);
    chk1("flush_no_stall", stall, 1'b0);
    tick();
    drive(0, 0, 4'b1110, 0, 4'b0000, 0, 0, 0);
    chk1("flush_err", err, 1'b0);
    tick();
    tick();

    // Freeze holds P[0]; the write lands after release.
    drive(1, 1, 4'b1110, 0, 4'b0000, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 4'b0000, 0, 4'b0000, 1, 0, 0);
      chk1("freeze_stall", stall, 1'b1);
      tick();
    end
    drive(1, 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    chk1("release_stall", stall, 1'b1);
    tick();
    drive(1, 0, 4'b0000, 1, 4'b0110, 0, 0, 0);
    chk1("release_no_stall", stall, 1'b0);
    chk1("release_bypass_z", flag_z, 1'b1);
    tick();
    drive(0, 0, 4'b1110, 0, 4'b0000, 0, 0, 0);
    chk1("release_err", err, 1'b0);
    tick();

    // Untracked write sets sticky err until reset.
    drive(0, 0, 4'b1110, 1, 4'b1010, 0, 0, 0);
    chk1("proto_err_before", err, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 4'b1110, 0, 4'b0000, 0, 0, 0);
      chk1("proto_err_sticky", err, 1'b1);
      tick();
    end
    drive(0, 0, 4'b1110, 0, 4'b0000, 0, 0, 1);
    tick();
    drive(0, 0, 4'b1110, 0, 4'b0000, 0, 0, 0);
    chk1("proto_err_cleared", err, 1'b0);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      r    = ($urandom_range(0, 99) < (m_err ? 20 : 2));
      frz  = ($urandom_range(0, 99) < 12);
      flsh = ($urandom_range(0, 99) < 8);
      v    = ($urandom_range(0, 99) < 75);
      s    = ($urandom_range(0, 99) < 50);
      c    = 4'($urandom_range(0, 15));
      wr   = m_top() ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 4);
      fl   = 4'($urandom_range(0, 15));
      drive(v, s, c, wr, fl, frz, flsh, r);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/status_register_unit.md
# status_register_unit

- Holds the architectural NZCV flags and feeds them to the ID-stage condition checker.
- Updates the flags when a flag-setting (S-bit) instruction completes in EXE, and bypasses the new flags combinationally in that same cycle.
- Tracks flag-setting instructions still in flight between ID and the flag write, and stalls ID when a conditional instruction would otherwise read stale flags.
- Sits between the EXE-stage ALU flag outputs and the ID-stage condition check.

## Interface
Parameters:
- PIPE_DEPTH, default 2: cycles from ID issue to the EXE flag write; allowed range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- id_valid  in  1  ID holds a valid instruction that advances this cycle unless stalled or frozen.
- id_s  in  1  ID instruction sets flags.
- id_cond  in  4  ID instruction condition field.
- exe_wr  in  1  EXE commits flags this cycle.
- exe_flags  in  4  new flags {N,Z,C,V}, bit 3 = N.
- freeze  in  1  whole pipeline held, e.g. by a memory stall.
- flush  in  1  taken branch; kills younger in-flight instructions.
- flag_n, flag_z, flag_c, flag_v  out  1 each  flags presented to the condition check.
- stall  out  1  ID must hold this cycle.
- err  out  1  sticky protocol-error flag.

## Operation
State:
- Flags register F, 4 bits.
- Pending vector P[0..PIPE_DEPTH-1]. P[k] = a flag setter issued k+1 cycles ago has not yet written.

Flag outputs:
- {flag_n,flag_z,flag_c,flag_v} = exe_wr ? exe_flags : F. This is the zero-latency bypass.

Uses-flags rule:
- An instruction uses the flags iff id_cond is not 4'b1110 (AL) and not 4'b1111 (NV).

Stall:
- stall = id_valid & uses-flags & |P[0..PIPE_DEPTH-2].
- P[PIPE_DEPTH-1] never causes a stall; the bypass covers it.
- With PIPE_DEPTH=1, stall is constant 0.

Issue:
- issue = id_valid & id_s & ~stall & ~freeze & ~flush.

Per edge, in priority order:
- rst: F=4'b0000, P=0, err=0.
- freeze (and not rst): P and err hold. F still loads exe_flags if exe_wr is high.
- flush (and not rst or freeze): P cleared to all zeros. A coincident exe_wr still commits to F, because that write belongs to the older branch-side instruction.
- Otherwise:
  - P[0] <= issue.
  - P[k] <= P[k-1] for k = 1..PIPE_DEPTH-1.
  - F <= exe_flags if exe_wr.

Error detection:
- err sets and stays set if exe_wr=1 while P[PIPE_DEPTH-1]=0 and no flush occurred within the previous PIPE_DEPTH cycles.
- A write with no tracked setter is a protocol violation.
- Hold the post-flush masking window in a small counter.

## Timing
- Flag outputs: combinational from exe_wr/exe_flags/F; no added latency.
- stall: combinational from P, id_valid and id_cond. The upstream register must not feed stall back into id_valid within the same cycle.
- An S-instruction issued at cycle t sets P[0] at t+1 and reaches P[PIPE_DEPTH-1] at t+PIPE_DEPTH, which is when exe_wr is expected.
- Reset values: F=0, so all flags read 0 unless exe_wr is high; stall=0; err=0.
- Back-to-back S-instructions are allowed. Each occupies its own P bit, and consecutive writes overwrite F.
- rst mid-operation discards all pending state in the same edge.

## Structure
- Shared package arm_pkg holds:
  - COND_AL=4'b1110 and COND_NV=4'b1111;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- The condition checker uses the same package.
- One sub-module, flag_pending_pipe, contains:
  - the P shift register with its flush/freeze rules;
  - the post-flush window counter for err masking.
- The top level holds F, the bypass mux and the stall logic.

## Test plan
All scenarios use PIPE_DEPTH=2.
- Reset:
  - Stimulus: rst for 2 cycles with exe_wr=1, exe_flags=4'b1111.
  - Response: during reset the outputs follow the bypass. The cycle after, with exe_wr=0, the flags read 0000 and stall=0 and err=0.
- RAW stall:
  - Stimulus: S-instruction at t; conditional EQ (id_cond=0000) presented at t+1; exe_wr=1, exe_flags=0100 at t+2.
  - Response: stall=1 at t+1, stall=0 at t+2, flag_z=1 at t+2 via the bypass, and F=0100 from t+3.
- AL and NV never stall:
  - Stimulus: S-instruction followed immediately by id_cond=1110, then by id_cond=1111.
  - Response: stall=0 in both cases.
- Flush:
  - Stimulus: S-instruction issued at t; flush at t+1; EQ presented at t+2.
  - Response: stall=0 at t+2, P all zero, err=0. A stray exe_wr at t+2 does not set err because it falls inside the masking window.
- Freeze:
  - Stimulus: freeze held for 3 cycles at t+1 after an S-instruction issued at t.
  - Response: P[0] stays 1 through the freeze and stall stays asserted for a conditional instruction. After release, P advances and the write lands on schedule.
- Protocol error:
  - Stimulus: exe_wr=1 with no issued setter and no recent flush.
  - Response: err=1 from the next cycle onward, and it stays 1 until rst.
